// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg
// Shared definitions for the mac_pipe multiply-accumulate slice.
//   - beat_tag_t     : per-beat control tags carried alongside the product
//   - acc_width()    : accumulator width derivation (2*DATA_W + GUARD_W)
//   - sat_max()      : saturation upper bound for a given width / signedness
//   - sat_min()      : saturation lower bound for a given width / signedness
// The sat_* functions return MAX_ACC_W-bit values; callers keep the low
// ACC_W bits.
// ============================================================================
package mac_pkg;

    localparam int MAX_ACC_W = 128;

    // Control tags that travel with a beat through stage 1.
    typedef struct packed {
        logic first;
        logic last;
        logic is_signed;
    } beat_tag_t;

    function automatic int acc_width(input int data_w, input int guard_w);
        return 2 * data_w + guard_w;
    endfunction

    // Unsigned: all ones. Signed: 2^(acc_w-1) - 1.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w, input logic is_signed);
        logic [MAX_ACC_W-1:0] ones;
        ones = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - acc_w);
        if (is_signed) begin
            return ones >> 1;
        end else begin
            return ones;
        end
    endfunction

    // Unsigned: 0. Signed: -2^(acc_w-1), i.e. only the sign bit set.
    function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w, input logic is_signed);
        logic [MAX_ACC_W-1:0] one_hot;
        one_hot = {{(MAX_ACC_W-1){1'b0}}, 1'b1} << (acc_w - 1);
        if (is_signed) begin
            return one_hot;
        end else begin
            return {MAX_ACC_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/mac_mult.sv
// ============================================================================
// mac_mult
// Combinational DATA_W x DATA_W multiplier, signed or unsigned per beat.
// Both operands are extended to 2*DATA_W bits (sign or zero) and multiplied;
// the low 2*DATA_W bits are the exact product in either mode, so a single
// multiplier serves both.
// Ports:
//   a, b      : operands (DATA_W)
//   is_signed : 1 = two's-complement operands
//   prod      : full-width product (2*DATA_W)
// ============================================================================
module mac_mult #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                is_signed,
    output logic [2*DATA_W-1:0] prod
);

    logic [2*DATA_W-1:0] a_ext_s;
    logic [2*DATA_W-1:0] b_ext_s;

    assign a_ext_s = {{DATA_W{is_signed & a[DATA_W-1]}}, a};
    assign b_ext_s = {{DATA_W{is_signed & b[DATA_W-1]}}, b};
    assign prod    = a_ext_s * b_ext_s;

endmodule

// File: rtl/mac_pipe.sv
// ============================================================================
// mac_pipe
// Two-stage pipelined multiply-accumulate with valid/ready handshakes.
//   Stage 1: registers the full product plus first/last/signed tags.
//   Stage 2: accumulates into ACC_W bits and emits the run result on the
//            last beat. Overflow is sticky for the run.
// A pending result that the consumer has not taken stalls both stages.
// Build option: define MAC_PIPE_SAT_EN to clamp on overflow instead of
// wrapping modulo 2^ACC_W (out_ovf behaves the same in both builds).
// Ports:
//   SYS_CLK, SYS_RST (async, active-low)
//   in_valid/in_ready, in_a, in_b, in_first, in_last, signed_mode
//   out_valid/out_ready, out_acc (ACC_W), out_ovf
// ============================================================================
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GUARD_W = 8
) (
    input  logic                          SYS_CLK,
    input  logic                          SYS_RST,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_a,
    input  logic [DATA_W-1:0]             in_b,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          signed_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DATA_W+GUARD_W-1:0]   out_acc,
    output logic                          out_ovf
);

    localparam int ACC_W  = acc_width(DATA_W, GUARD_W);
    localparam int PROD_W = 2 * DATA_W;

`ifdef MAC_PIPE_SAT_EN
    localparam logic [MAX_ACC_W-1:0] U_MAX_FULL = sat_max(ACC_W, 1'b0);
    localparam logic [MAX_ACC_W-1:0] S_MAX_FULL = sat_max(ACC_W, 1'b1);
    localparam logic [MAX_ACC_W-1:0] S_MIN_FULL = sat_min(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0]     U_MAX      = U_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     S_MAX      = S_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     S_MIN      = S_MIN_FULL[ACC_W-1:0];
`endif

    // ---------------- handshake ----------------
    logic stall_s;
    logic accept_s;

    // ---------------- stage 1 ----------------
    logic              beat_signed_s;
    logic [PROD_W-1:0] mult_prod_s;
    logic              mode_r;
    logic              s1_valid_r;
    logic [PROD_W-1:0] s1_prod_r;
    beat_tag_t         s1_tag_r;

    // ---------------- stage 2 ----------------
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] base_acc_s;
    logic             base_ovf_s;
    logic [ACC_W:0]   sum_wide_s;
    logic             ovf_step_s;
    logic [ACC_W-1:0] next_acc_s;
    logic             next_ovf_s;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;
    logic [ACC_W-1:0] out_acc_r;
    logic             out_ovf_r;
    logic             out_valid_r;

    assign stall_s  = out_valid_r & ~out_ready;
    assign accept_s = in_valid & ~stall_s;
    assign in_ready = ~stall_s;

    // A first beat uses its own mode; later beats use the mode latched for the run.
    assign beat_signed_s = in_first ? signed_mode : mode_r;

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a         (in_a),
        .b         (in_b),
        .is_signed (beat_signed_s),
        .prod      (mult_prod_s)
    );

    // Run signedness latch, updated on every accepted first beat.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            mode_r <= 1'b0;
        end else if (accept_s && in_first) begin
            mode_r <= signed_mode;
        end
    end

    // Stage 1 register: product and tags, frozen while stalled.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= '0;
            s1_tag_r   <= '0;
        end else if (!stall_s) begin
            s1_valid_r         <= in_valid;
            s1_prod_r          <= mult_prod_s;
            s1_tag_r.first     <= in_valid & in_first;
            s1_tag_r.last      <= in_valid & in_last;
            s1_tag_r.is_signed <= beat_signed_s;
        end
    end

    assign prod_ext_s = s1_tag_r.is_signed ? {{GUARD_W{s1_prod_r[PROD_W-1]}}, s1_prod_r}
                                           : {{GUARD_W{1'b0}}, s1_prod_r};

    // Accumulation base: a first beat restarts from zero with a clean ovf flag.
    always_comb begin
        base_acc_s = acc_r;
        base_ovf_s = ovf_r;
        if (s1_tag_r.first) begin
            base_acc_s = '0;
            base_ovf_s = 1'b0;
        end else begin
            base_acc_s = acc_r;
            base_ovf_s = ovf_r;
        end
    end

    assign sum_wide_s = {1'b0, base_acc_s} + {1'b0, prod_ext_s};

    // Signed overflow: like-signed operands giving an opposite-signed sum.
    always_comb begin
        ovf_step_s = 1'b0;
        if (s1_tag_r.is_signed) begin
            ovf_step_s = (base_acc_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                         (sum_wide_s[ACC_W-1] != base_acc_s[ACC_W-1]);
        end else begin
            ovf_step_s = sum_wide_s[ACC_W];
        end
    end

    assign next_ovf_s = base_ovf_s | ovf_step_s;

    // Next accumulator value: wrap, or clamp and stay clamped for the run.
    always_comb begin
        next_acc_s = sum_wide_s[ACC_W-1:0];
`ifdef MAC_PIPE_SAT_EN
        if (base_ovf_s) begin
            next_acc_s = base_acc_s;
        end else if (ovf_step_s) begin
            if (!s1_tag_r.is_signed) begin
                next_acc_s = U_MAX;
            end else if (prod_ext_s[ACC_W-1]) begin
                next_acc_s = S_MIN;
            end else begin
                next_acc_s = S_MAX;
            end
        end else begin
            next_acc_s = sum_wide_s[ACC_W-1:0];
        end
`else
        next_acc_s = sum_wide_s[ACC_W-1:0];
`endif
    end

    // Stage 2 register: accumulator update and result emission.
    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            out_acc_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (!stall_s) begin
            // Not stalled: any held result is either absent or handed off now.
            out_valid_r <= s1_valid_r & s1_tag_r.last;
            if (s1_valid_r) begin
                if (s1_tag_r.last) begin
                    out_acc_r <= next_acc_s;
                    out_ovf_r <= next_ovf_s;
                    acc_r     <= '0;
                    ovf_r     <= 1'b0;
                end else begin
                    acc_r     <= next_acc_s;
                    ovf_r     <= next_ovf_s;
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_ovf   = out_ovf_r;

endmodule
